// File: rtl/lifo_reader.sv
// ---------------------------------------------------------------------------
// lifo_reader
//
// Read-side master for the lifo block. A burst is started with cmd_start and
// pops cmd_len entries from the lifo, or drains it until empty when
// cmd_len == 0. Popped words are delivered on a valid/ready output stream
// through a 2-entry skid buffer. Downstream backpressure therefore never
// drops a word, and the lifo is never popped while it is empty.
//
// Configuration macro: LIFO_READER_FWFT_EN
//   undefined : the lifo has 1-cycle read latency. r_data is valid the cycle
//               after r_req, and a 1-bit in-flight flag tracks that word.
//   defined   : the lifo is in FWFT mode. r_data is valid in the same cycle
//               as r_req and is captured at that edge. There is no in-flight
//               flag.
//
// Parameters
//   DATA_W : width of lifo words and of out_data
//   DEPTH  : depth of the attached lifo
//   CNT_W  : width of lifo_cnt, cmd_len and popped_cnt
//
// Ports
//   clk200      in   clock
//   nrst        in   synchronous, active-low reset
//   cmd_start   in   one-cycle pulse that starts a burst; ignored while busy
//   cmd_len     in   entries to pop; 0 = drain until lifo_empty
//   cmd_busy    out  high from the cycle after an accepted start until done
//   cmd_done    out  one-cycle pulse when the burst completes
//   popped_cnt  out  entries popped in the current/last burst (saturating)
//   short_err   out  sticky: lifo emptied before cmd_len pops
//   r_req       out  pop request to the lifo
//   r_data      in   lifo read data
//   lifo_empty  in   lifo empty flag
//   lifo_cnt    in   lifo fill count (status only, not used for control)
//   out_valid   out  output word valid
//   out_ready   in   downstream accept
//   out_data    out  output word
//   dbg_state   out  current FSM state, for debug and checkers
//
// Handshake: a word transfers on every clk200 edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_valid and
// out_data hold their values. out_valid never depends on out_ready.
// ---------------------------------------------------------------------------
module lifo_reader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk200,
    input  logic              nrst,
    input  logic              cmd_start,
    input  logic [CNT_W-1:0]  cmd_len,
    output logic              cmd_busy,
    output logic              cmd_done,
    output logic [CNT_W-1:0]  popped_cnt,
    output logic              short_err,
    output logic              r_req,
    input  logic [DATA_W-1:0] r_data,
    input  logic              lifo_empty,
    input  logic [CNT_W-1:0]  lifo_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cmd_len_q, cmd_len_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   popped_q, popped_d;
    logic               short_err_q, short_err_d;

    // Skid buffer: two entries, with read/write pointers and an occupancy count.
    logic [DATA_W-1:0]  buf_q [2];
    logic [DATA_W-1:0]  buf_d [2];
    logic [1:0]         buf_cnt_q, buf_cnt_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;

    logic               inflight;   // a popped word is still on its way from the lifo
    logic               capture;    // write r_data into the skid buffer at this edge
    logic               pop_out;    // head word leaves on the output stream
    logic [2:0]         held;
    logic               space;
    logic               more_ok;
    logic               r_req_w;

    // lifo_cnt is status only; fold it into a sink so it is not left dangling.
    logic               lifo_cnt_unused;
    assign lifo_cnt_unused = ^lifo_cnt;

`ifdef LIFO_READER_FWFT_EN
    // FWFT: the word is present with r_req and is captured at the same edge.
    assign inflight = 1'b0;
    assign capture  = r_req_w;
`else
    logic inflight_q, inflight_d;

    assign inflight   = inflight_q;
    assign capture    = inflight_q;
    assign inflight_d = r_req_w;

    always_ff @(posedge clk200) begin
        if (!nrst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end
`endif

    assign pop_out = (buf_cnt_q != 2'd0) && out_ready;

    // Words the reader still holds after this edge, not counting a new
    // request. The word that leaves downstream in this cycle is subtracted.
    // That lets a steady out_ready=1 stream sustain one pop per cycle, while
    // buffer plus in-flight words never exceed two.
    always_comb begin
        held  = {1'b0, buf_cnt_q} + {2'b00, inflight} - {2'b00, pop_out};
        space = (held < 3'd2);
    end

    assign more_ok = (remaining_q != '0) || (cmd_len_q == '0);
    assign r_req_w = (state_q == S_POP) && !lifo_empty && space && more_ok;

    // Burst control FSM.
    always_comb begin
        state_d     = state_q;
        cmd_len_d   = cmd_len_q;
        remaining_d = remaining_q;
        popped_d    = popped_q;
        short_err_d = short_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    cmd_len_d   = cmd_len;
                    remaining_d = cmd_len;
                    popped_d    = '0;
                    short_err_d = 1'b0;
                    state_d     = S_POP;
                end
            end
            S_POP: begin
                if (r_req_w) begin
                    if (popped_q != CNT_MAX) begin
                        popped_d = popped_q + CNT_ONE;
                    end
                    // In drain mode remaining stays 0 and is not counted.
                    if (cmd_len_q != '0) begin
                        remaining_d = remaining_q - CNT_ONE;
                        if (remaining_q == CNT_ONE) begin
                            state_d = S_FLUSH;
                        end
                    end
                end else if (lifo_empty) begin
                    state_d = S_FLUSH;
                    if ((cmd_len_q != '0) && (remaining_q != '0)) begin
                        short_err_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!inflight && (buf_cnt_q == 2'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skid buffer next-state. A capture and a pop can happen in the same cycle.
    always_comb begin
        buf_d[0]  = buf_q[0];
        buf_d[1]  = buf_q[1];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        buf_cnt_d = buf_cnt_q + {1'b0, capture} - {1'b0, pop_out};
        if (capture) begin
            buf_d[wr_ptr_q] = r_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_out) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk200) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            cmd_len_q   <= '0;
            remaining_q <= '0;
            popped_q    <= '0;
            short_err_q <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            buf_cnt_q   <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_len_q   <= cmd_len_d;
            remaining_q <= remaining_d;
            popped_q    <= popped_d;
            short_err_q <= short_err_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
            buf_cnt_q   <= buf_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    assign cmd_busy   = (state_q != S_IDLE);
    assign cmd_done   = (state_q == S_DONE);
    assign popped_cnt = popped_q;
    assign short_err  = short_err_q;
    assign r_req      = r_req_w;
    assign out_valid  = (buf_cnt_q != 2'd0);
    assign out_data   = buf_q[rd_ptr_q];
    assign dbg_state  = state_q;

endmodule
